// File: rtl/hash_pipe_if.sv
// Key/hash handshake and table-write bus for hash_pipe.
`timescale 1ns/1ps
interface hash_if #(
  parameter int KEY_BYTES = 3,
  parameter int IDX_W     = 12
);
  logic                   in_valid;
  logic                   in_ready;
  logic [8*KEY_BYTES-1:0] in_key;
  logic                   out_valid;
  logic                   out_ready;
  logic [IDX_W-1:0]       out_hash;
  logic                   tbl_we;
  logic [IDX_W-1:0]       tbl_addr;
  logic [IDX_W-1:0]       tbl_wdata;
  logic                   busy;

  modport master (
    output in_valid, in_key, out_ready, tbl_we, tbl_addr, tbl_wdata,
    input  in_ready, out_valid, out_hash, busy
  );

  modport slave (
    input  in_valid, in_key, out_ready, tbl_we, tbl_addr, tbl_wdata,
    output in_ready, out_valid, out_hash, busy
  );
endinterface

// File: rtl/hash_pipe.sv
// Pipelined table-driven byte hash: one table lookup per stage, one key per cycle,
// with a writable lookup table that resets to identity.
`timescale 1ns/1ps
module hash_pipe #(
  parameter int KEY_BYTES = 3,
  parameter int IDX_W     = 12
) (
  input  logic clk,
  input  logic reset,
  hash_if.slave bus
);
  localparam int DEPTH = 1 << IDX_W;
  localparam int KW    = 8 * KEY_BYTES;

  logic [IDX_W-1:0]     tbl_q [DEPTH];
  logic [IDX_W-1:0]     tbl_d [DEPTH];
  logic [KEY_BYTES-1:0] vld_q, vld_d;
  logic [IDX_W-1:0]     h_q   [KEY_BYTES];
  logic [IDX_W-1:0]     h_d   [KEY_BYTES];
  logic [KW-1:0]        key_q [KEY_BYTES];
  logic [KW-1:0]        key_d [KEY_BYTES];
  logic                 stall;
  logic                 accept;

  // Table: reset wins over a write in the same cycle.
  always_comb begin
    tbl_d = tbl_q;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) tbl_d[i] = IDX_W'(i);
    end else if (bus.tbl_we) begin
      tbl_d[bus.tbl_addr] = bus.tbl_wdata;
    end
  end

  // Every stage reads the pre-write table, so a concurrent write is seen only downstream.
  always_comb begin
    stall  = vld_q[KEY_BYTES-1] & ~bus.out_ready;
    accept = bus.in_valid & bus.in_ready;
    vld_d  = vld_q;
    h_d    = h_q;
    key_d  = key_q;
    if (!stall) begin
      vld_d[0] = accept;
      h_d[0]   = tbl_q[IDX_W'(bus.in_key[7:0])];
      key_d[0] = bus.in_key >> 8;
      for (int i = 1; i < KEY_BYTES; i++) begin
        vld_d[i] = vld_q[i-1];
        h_d[i]   = tbl_q[IDX_W'(key_q[i-1][7:0]) ^ h_q[i-1]];
        key_d[i] = key_q[i-1] >> 8;
      end
    end
    if (reset) begin
      vld_d = '0;
      for (int i = 0; i < KEY_BYTES; i++) begin
        h_d[i]   = '0;
        key_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    tbl_q <= tbl_d;
    vld_q <= vld_d;
    h_q   <= h_d;
    key_q <= key_d;
  end

  assign bus.in_ready  = ~stall & ~bus.tbl_we & ~reset;
  assign bus.out_valid = vld_q[KEY_BYTES-1] & ~reset;
  assign bus.out_hash  = reset ? '0 : h_q[KEY_BYTES-1];
  assign bus.busy      = (|vld_q) & ~reset;
endmodule

// File: tb/tb_hash_pipe.sv
// Directed self-checking bench for hash_pipe (KEY_BYTES=3, IDX_W=12).
`timescale 1ns/1ps
module tb_hash_pipe;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  hash_if #(.KEY_BYTES(3), .IDX_W(12)) bus ();

  hash_pipe #(.KEY_BYTES(3), .IDX_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Identity table: hash is the XOR of the three key bytes.
  logic [23:0] skey [8] = '{24'h000001, 24'h000102, 24'h0A0B0C, 24'hFF0000,
                            24'h123456, 24'h808080, 24'h0F0F01, 24'hA5C3E7};
  logic [11:0] sexp [8] = '{12'h001, 12'h003, 12'h00D, 12'h0FF,
                            12'h070, 12'h080, 12'h001, 12'h081};
  logic [23:0] bkey [5] = '{24'h000011, 24'h002200, 24'h330000, 24'h010101, 24'h7F00FF};
  logic [11:0] bexp [5] = '{12'h011, 12'h022, 12'h033, 12'h001, 12'h080};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Empty pipeline, out_ready=1: accept one key, expect it after two further edges.
  task automatic run_key(input logic [23:0] key, input logic [11:0] exp, input string tag);
    int n;
    bus.in_valid = 1'b1;
    bus.in_key   = key;
    step();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check({tag, "_lat"}, n, 2);
    check(tag, {20'd0, bus.out_hash}, {20'd0, exp});
    step();
  endtask

  task automatic write_tbl(input logic [11:0] addr, input logic [11:0] data);
    bus.tbl_we    = 1'b1;
    bus.tbl_addr  = addr;
    bus.tbl_wdata = data;
    step();
    bus.tbl_we = 1'b0;
  endtask

  initial begin
    int rcv, sent, first, last, gap_ok, seen;
    logic fire_in, fire_out;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_key    = '0;
    bus.out_ready = 1'b1;
    bus.tbl_we    = 1'b0;
    bus.tbl_addr  = '0;
    bus.tbl_wdata = '0;
    step();
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_hash", bus.out_hash, 0);
    reset = 1'b0;
    #1;
    check("idle_in_ready", bus.in_ready, 1);
    check("idle_out_valid", bus.out_valid, 0);
    check("idle_busy", bus.busy, 0);

    // h1=1, h2=T[2^1]=3, h3=T[3^3]=0
    run_key(24'h030201, 12'h000, "id_030201");
    run_key(24'h0000AB, 12'h0AB, "id_0000ab");

    // Back-to-back stream
    rcv = 0; first = -1; last = -1; gap_ok = 1;
    for (int c = 0; c < 12; c++) begin
      if (c < 8) begin
        bus.in_valid = 1'b1;
        bus.in_key   = skey[c];
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (bus.out_valid === 1'b1) begin
        if (rcv < 8) check("stream_data", {20'd0, bus.out_hash}, {20'd0, sexp[rcv]});
        if (first < 0) first = c;
        else if (c != last + 1) gap_ok = 0;
        last = c;
        rcv++;
      end
    end
    check("stream_count", rcv, 8);
    check("stream_first", first, 2);
    check("stream_gap", gap_ok, 1);

    // Programmed table
    bus.tbl_we    = 1'b1;
    bus.tbl_addr  = 12'h001;
    bus.tbl_wdata = 12'hABC;
    bus.in_valid  = 1'b1;
    #1;
    check("we_in_ready", bus.in_ready, 0);
    step();
    bus.tbl_we   = 1'b0;
    bus.in_valid = 1'b0;
    write_tbl(12'hABE, 12'h123);
    write_tbl(12'h120, 12'h456);
    check("we_no_accept", bus.busy, 0);
    // ABC, T[ABC^2]=123, T[123^3]=456
    run_key(24'h030201, 12'h456, "tbl_030201");
    // ABC, T[ABC^3]=ABF, T[ABF^2]=ABD
    run_key(24'h020301, 12'hABD, "tbl_020301");
    write_tbl(12'h001, 12'hFFF);
    run_key(24'h000001, 12'hFFF, "tbl_000001");

    reset = 1'b1;
    step();
    reset = 1'b0;

    // Backpressure with a full pipeline
    rcv = 0; sent = 0;
    for (int c = 0; c < 25; c++) begin
      bus.out_ready = (c >= 8);
      bus.in_valid  = (sent < 5);
      bus.in_key    = (sent < 5) ? bkey[sent] : 24'h0;
      #1;
      fire_in  = bus.in_valid & bus.in_ready;
      fire_out = bus.out_valid & bus.out_ready;
      if (c >= 3 && c < 8) begin
        check("bp_in_ready", bus.in_ready, 0);
        check("bp_hold", {20'd0, bus.out_hash}, {20'd0, bexp[0]});
        check("bp_valid", bus.out_valid, 1);
      end
      if (fire_out === 1'b1) begin
        if (rcv < 5) check("bp_data", {20'd0, bus.out_hash}, {20'd0, bexp[rcv]});
        rcv++;
      end
      if (fire_in === 1'b1) sent++;
      step();
    end
    check("bp_count", rcv, 5);
    check("bp_sent", sent, 5);
    check("bp_busy", bus.busy, 0);

    // Table write with two keys in flight.
    // P=050000: its last lookup of T[5] coincides with the write -> old 005.
    // Q=000500: stage 2 reads old T[5]=5, stage 3 reads new T[5]=777.
    // R=000005 held across the write cycle, accepted next: all lookups new -> 777.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_key    = 24'h050000;
    step();
    bus.in_key    = 24'h000500;
    step();
    bus.in_key    = 24'h000005;
    bus.tbl_we    = 1'b1;
    bus.tbl_addr  = 12'h005;
    bus.tbl_wdata = 12'h777;
    #1;
    check("fly_in_ready", bus.in_ready, 0);
    step();
    bus.tbl_we = 1'b0;
    check("fly_p_valid", bus.out_valid, 1);
    check("fly_p_hash", bus.out_hash, 12'h005);
    step();
    bus.in_valid = 1'b0;
    check("fly_q_valid", bus.out_valid, 1);
    check("fly_q_hash", bus.out_hash, 12'h777);
    step();
    check("fly_bubble", bus.out_valid, 0);
    step();
    check("fly_r_valid", bus.out_valid, 1);
    check("fly_r_hash", bus.out_hash, 12'h777);
    step();
    check("fly_busy", bus.busy, 0);

    // Reset mid-stream, with a competing table write that must be ignored
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.in_key = 24'(c + 1);
      step();
    end
    bus.in_valid = 1'b0;
    check("rr_pre_valid", bus.out_valid, 1);
    reset         = 1'b1;
    bus.tbl_we    = 1'b1;
    bus.tbl_addr  = 12'h0AB;
    bus.tbl_wdata = 12'h111;
    #1;
    check("rr_out_valid", bus.out_valid, 0);
    check("rr_out_hash", bus.out_hash, 0);
    check("rr_busy", bus.busy, 0);
    check("rr_in_ready", bus.in_ready, 0);
    step();
    reset      = 1'b0;
    bus.tbl_we = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid !== 1'b0) seen = 1;
      step();
    end
    check("rr_no_emerge", seen, 0);
    run_key(24'h0000AB, 12'h0AB, "rr_0000ab");
    run_key(24'h000005, 12'h005, "rr_000005");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
